// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use stalls, data-memory wait stalls, redirect flushes and EX forwarding selects.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [REG_AW-1:0] iRs1D,
    input  logic [REG_AW-1:0] iRs2D,
    input  logic              iUseRs1D,
    input  logic              iUseRs2D,
    input  logic [REG_AW-1:0] iRs1E,
    input  logic [REG_AW-1:0] iRs2E,
    input  logic [REG_AW-1:0] iRdE,
    input  logic              iIsLoadE,
    input  logic [REG_AW-1:0] iRdM,
    input  logic              iRegWriteM,
    input  logic [REG_AW-1:0] iRdW,
    input  logic              iRegWriteW,
    input  logic              iRedirectE,
    input  logic              iMemBusyM,
    output logic              oStallF,
    output logic              oStallD,
    output logic              oStallE,
    output logic              oStallM,
    output logic              oFlushD,
    output logic              oFlushE,
    output logic              oFlushW,
    output logic [1:0]        oFwdAE,
    output logic [1:0]        oFwdBE,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  oStallCnt,
    output logic [CNT_W-1:0]  oFlushCnt,
`endif
    output logic [1:0]        oState
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LDSTALL    = 2'b01,
        ST_MEMWAIT    = 2'b10,
        ST_REDIR_PEND = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic   pend_q, pend_d;

    // Forwarding: one identical selector per EX operand, M result beats W result.
    logic [REG_AW-1:0] rs_e [2];
    logic [1:0]        fwd_sel [2];

    assign rs_e[0] = iRs1E;
    assign rs_e[1] = iRs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_m, hit_w;
            assign hit_m = iRegWriteM && (iRdM != '0) && (iRdM == rs_e[gi]);
            assign hit_w = iRegWriteW && (iRdW != '0) && (iRdW == rs_e[gi]);
            assign fwd_sel[gi] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
        end
    endgenerate

    logic loaduse;
    assign loaduse = iIsLoadE && (iRdE != '0) &&
                     ((iUseRs1D && (iRs1D == iRdE)) || (iUseRs2D && (iRs2D == iRdE)));

    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic redir_flush;
    logic apply_run;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        redir_flush = 1'b0;
        apply_run   = 1'b0;

        if (iRst) begin
            state_d = ST_RUN;
            pend_d  = 1'b0;
        end else if (iMemBusyM) begin
            // Freeze F..M and bubble W; a redirect seen now is remembered, not applied.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
            state_d = ST_MEMWAIT;
            pend_d  = pend_q | iRedirectE;
        end else begin
            case (state_q)
                ST_MEMWAIT: begin
                    if (pend_q) state_d = ST_REDIR_PEND;
                    else        apply_run = 1'b1;
                end
                ST_REDIR_PEND: begin
                    flush_d     = 1'b1;
                    flush_e     = 1'b1;
                    redir_flush = 1'b1;
                    pend_d      = 1'b0;
                    state_d     = ST_RUN;
                end
                default: apply_run = 1'b1;
            endcase

            if (apply_run) begin
                if (iRedirectE) begin
                    // The D instruction is squashed, so a coincident load-use is moot.
                    flush_d     = 1'b1;
                    flush_e     = 1'b1;
                    redir_flush = 1'b1;
                    state_d     = ST_RUN;
                end else if (loaduse) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    state_d = ST_LDSTALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign oStallF = stall_f;
    assign oStallD = stall_d;
    assign oStallE = stall_e;
    assign oStallM = stall_m;
    assign oFlushD = flush_d;
    assign oFlushE = flush_e;
    assign oFlushW = flush_w;
    assign oFwdAE  = iRst ? 2'b00 : fwd_sel[0];
    assign oFwdBE  = iRst ? 2'b00 : fwd_sel[1];
    assign oState  = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Only redirect flushes are counted; load-use bubbles are stalls already.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f)     stall_cnt_q <= stall_cnt_q + 1'b1;
            if (redir_flush) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign oStallCnt = stall_cnt_q;
    assign oFlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed table-driven bench for hazard_controller plus multi-cycle sequences.
module tb_hazard_controller;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic [4:0] iRs1D = '0, iRs2D = '0, iRs1E = '0, iRs2E = '0, iRdE = '0, iRdM = '0, iRdW = '0;
    logic       iUseRs1D = 1'b0, iUseRs2D = 1'b0, iIsLoadE = 1'b0, iRegWriteM = 1'b0;
    logic       iRegWriteW = 1'b0, iRedirectE = 1'b0, iMemBusyM = 1'b0;
    logic       oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE, oFlushW;
    logic [1:0] oFwdAE, oFwdBE, oState;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] oStallCnt, oFlushCnt;
`endif

    hazard_controller #(.REG_AW(5), .CNT_W(32)) dut (
        .iClk(iClk), .iRst(iRst),
        .iRs1D(iRs1D), .iRs2D(iRs2D), .iUseRs1D(iUseRs1D), .iUseRs2D(iUseRs2D),
        .iRs1E(iRs1E), .iRs2E(iRs2E), .iRdE(iRdE), .iIsLoadE(iIsLoadE),
        .iRdM(iRdM), .iRegWriteM(iRegWriteM), .iRdW(iRdW), .iRegWriteW(iRegWriteW),
        .iRedirectE(iRedirectE), .iMemBusyM(iMemBusyM),
        .oStallF(oStallF), .oStallD(oStallD), .oStallE(oStallE), .oStallM(oStallM),
        .oFlushD(oFlushD), .oFlushE(oFlushE), .oFlushW(oFlushW),
        .oFwdAE(oFwdAE), .oFwdBE(oFwdBE),
`ifdef HAZARD_PERF_CNT_EN
        .oStallCnt(oStallCnt), .oFlushCnt(oFlushCnt),
`endif
        .oState(oState)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [4:0] rs1d, rs2d;
        logic       use1, use2;
        logic [4:0] rs1e, rs2e, rde;
        logic       isload;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww, redir, busy;
        logic [6:0] ctl;   // {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
        logic [1:0] fa, fb, ns;
    } vec_t;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LDU  = 7'b1100010;
    localparam logic [6:0] C_REDR = 7'b0000110;
    localparam logic [6:0] C_BUSY = 7'b1111001;

    int checks = 0;
    int errors = 0;

    function automatic logic [6:0] ctl_now();
        return {oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE, oFlushW};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Compare controls, forwarding selects and current state in one go.
    task automatic chk_out(input string name, input logic [6:0] c, input logic [1:0] fa,
                           input logic [1:0] fb, input logic [1:0] st);
        chk(name, {19'd0, ctl_now(), oFwdAE, oFwdBE, oState}, {19'd0, c, fa, fb, st});
        $display("%s ctl=%b fa=%b fb=%b st=%b", name, ctl_now(), oFwdAE, oFwdBE, oState);
    endtask

    task automatic drive(input vec_t v);
        iRs1D = v.rs1d; iRs2D = v.rs2d; iUseRs1D = v.use1; iUseRs2D = v.use2;
        iRs1E = v.rs1e; iRs2E = v.rs2e; iRdE = v.rde; iIsLoadE = v.isload;
        iRdM = v.rdm; iRegWriteM = v.rwm; iRdW = v.rdw; iRegWriteW = v.rww;
        iRedirectE = v.redir; iMemBusyM = v.busy;
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        vec_t idle;
        idle = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, C_NONE, 0,0,0};
        drive(idle);
        iRst = 1'b1;
        step();
        iRst = 1'b0;
    endtask

    vec_t vecs [13];
    vec_t idle_v, ldu_v, fwd_v, busy_v, busyr_v, ldu2_v;

    initial begin
        //          rs1d rs2d u1 u2 rs1e rs2e rde ld  rdm rwm rdw rww red bsy ctl    fa fb ns
        vecs[0]  = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, C_NONE, 0, 0, 0};
        vecs[1]  = '{5, 0, 1, 0,  0, 0, 5, 1,  0, 0, 0, 0,  0, 0, C_LDU,  0, 0, 1};
        vecs[2]  = '{0, 0, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0, C_NONE, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0,  0, 3, 0, 0,  3, 1, 3, 1,  0, 0, C_NONE, 0, 2, 0};
        vecs[4]  = '{0, 0, 0, 0,  4, 0, 0, 0,  0, 0, 4, 1,  0, 0, C_NONE, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 1,  0, 0, C_NONE, 0, 0, 0};
        vecs[6]  = '{5, 0, 1, 0,  0, 0, 5, 1,  0, 0, 0, 0,  1, 0, C_REDR, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 1, C_BUSY, 0, 0, 2};
        vecs[8]  = '{0, 0, 0, 0,  7, 7, 0, 0,  7, 0, 7, 1,  0, 0, C_NONE, 1, 1, 0};
        vecs[9]  = '{0, 9, 0, 0,  0, 0, 9, 1,  0, 0, 0, 0,  0, 0, C_NONE, 0, 0, 0};
        vecs[10] = '{0, 9, 0, 1,  0, 0, 9, 1,  0, 0, 0, 0,  0, 0, C_LDU,  0, 0, 1};
        vecs[11] = '{5, 0, 1, 0,  0, 0, 5, 1,  0, 0, 0, 0,  1, 1, C_BUSY, 0, 0, 2};
        vecs[12] = '{0, 0, 0, 0,  2, 2, 0, 0,  2, 1, 2, 1,  0, 0, C_NONE, 2, 2, 0};

        idle_v  = vecs[0];
        ldu_v   = vecs[1];
        busy_v  = vecs[7];
        busyr_v = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 1, C_BUSY, 0, 0, 2};
        fwd_v   = '{0, 0, 0, 0,  5, 0, 0, 0,  5, 1, 0, 0,  0, 0, C_NONE, 2, 0, 0};
        ldu2_v  = '{0, 6, 0, 1,  0, 0, 6, 1,  0, 0, 0, 0,  0, 0, C_LDU,  0, 0, 1};

        step();
        step();
        // Reset state: everything quiet while iRst is held.
        @(negedge iClk);
        chk_out("reset_hold", C_NONE, 2'b00, 2'b00, 2'b00);

        for (int i = 0; i < 13; i++) begin
            do_reset();
            drive(vecs[i]);
            @(negedge iClk);
            chk_out($sformatf("vec%0d_out", i), vecs[i].ctl, vecs[i].fa, vecs[i].fb, 2'b00);
            step();
            chk($sformatf("vec%0d_next", i), {30'd0, oState}, {30'd0, vecs[i].ns});
        end

        // Load-use, then forwarded from M during LDSTALL.
        do_reset();
        drive(ldu_v);
        @(negedge iClk); chk_out("ldu_c0", C_LDU, 2'b00, 2'b00, 2'b00);
        step();
        drive(fwd_v);
        @(negedge iClk); chk_out("ldu_c1_fwd", C_NONE, 2'b10, 2'b00, 2'b01);
        step();
        drive(idle_v);
        @(negedge iClk); chk_out("ldu_c2", C_NONE, 2'b00, 2'b00, 2'b00);

        // Back-to-back load-use re-enters LDSTALL.
        do_reset();
        drive(ldu_v); step();
        drive(ldu2_v);
        @(negedge iClk); chk_out("b2b_ldu", C_LDU, 2'b00, 2'b00, 2'b01);
        step();
        drive(idle_v);
        @(negedge iClk); chk_out("b2b_ldu_after", C_NONE, 2'b00, 2'b00, 2'b01);

        // Reset held 2 cycles mid-LDSTALL.
        do_reset();
        drive(ldu_v); step();
        iRst = 1'b1;
        @(negedge iClk); chk_out("rst_mid_c0", C_NONE, 2'b00, 2'b00, 2'b01);
        step();
        @(negedge iClk); chk_out("rst_mid_c1", C_NONE, 2'b00, 2'b00, 2'b00);
        step();
        iRst = 1'b0;
        drive(idle_v);
        @(negedge iClk); chk_out("rst_mid_rel", C_NONE, 2'b00, 2'b00, 2'b00);

        // Busy 3 cycles, redirect pulsed in cycle 2.
        do_reset();
        drive(busy_v);
        @(negedge iClk); chk_out("mw_c1", C_BUSY, 2'b00, 2'b00, 2'b00);
        step();
        drive(busyr_v);
        @(negedge iClk); chk_out("mw_c2", C_BUSY, 2'b00, 2'b00, 2'b10);
        step();
        drive(busy_v);
        @(negedge iClk); chk_out("mw_c3", C_BUSY, 2'b00, 2'b00, 2'b10);
        step();
        drive(idle_v);
        @(negedge iClk); chk_out("mw_drop", C_NONE, 2'b00, 2'b00, 2'b10);
        step();
        @(negedge iClk); chk_out("mw_redir_pend", C_REDR, 2'b00, 2'b00, 2'b11);
        step();
        @(negedge iClk); chk_out("mw_run", C_NONE, 2'b00, 2'b00, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", oStallCnt, 32'd3);
        chk("flush_cnt", oFlushCnt, 32'd1);
`endif

        // Busy arriving in REDIR_PEND keeps the pending redirect.
        do_reset();
        drive(busyr_v); step();
        drive(idle_v); step();
        drive(busy_v);
        @(negedge iClk); chk_out("rp_busy", C_BUSY, 2'b00, 2'b00, 2'b11);
        step();
        drive(idle_v);
        @(negedge iClk); chk_out("rp_drop", C_NONE, 2'b00, 2'b00, 2'b10);
        step();
        @(negedge iClk); chk_out("rp_pend", C_REDR, 2'b00, 2'b00, 2'b11);
        step();
        @(negedge iClk); chk_out("rp_run", C_NONE, 2'b00, 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline sequencer for the 5-stage RV32I core: load-use stalls, data-memory wait stalls, and control-redirect flushes.
- Also produces the EX-stage operand forwarding selects.
- Sits beside the control/decode path. Consumes register indices and type flags from D/E/M/W pipeline registers, plus the redirect flag from the branch/jump resolution in E.
- Drives stall enables and flush (bubble-insert) controls on every pipeline register.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- iClk  in  1  clock, rising-edge
- iRst  in  1  synchronous, active-high reset
- iRs1D  in  REG_AW  rs1 index of instruction in D
- iRs2D  in  REG_AW  rs2 index of instruction in D
- iUseRs1D  in  1  D instruction reads rs1
- iUseRs2D  in  1  D instruction reads rs2
- iRs1E  in  REG_AW  rs1 index in E
- iRs2E  in  REG_AW  rs2 index in E
- iRdE  in  REG_AW  rd in E
- iIsLoadE  in  1  E instruction is LOAD
- iRdM  in  REG_AW  rd in M
- iRegWriteM  in  1  M writes rd
- iRdW  in  REG_AW  rd in W
- iRegWriteW  in  1  W writes rd
- iRedirectE  in  1  branch taken or JAL/JALR resolved in E
- iMemBusyM  in  1  data memory not ready for M access
- oStallF  out  1  hold PC
- oStallD  out  1  hold D register
- oStallE  out  1  hold E register
- oStallM  out  1  hold M register
- oFlushD  out  1  clear D register to NOP
- oFlushE  out  1  clear E register to NOP
- oFlushW  out  1  insert bubble into W (M held)
- oFwdAE  out  2  operand A select: 00 regfile, 01 W result, 10 M result
- oFwdBE  out  2  operand B select, same encoding
- oState  out  2  FSM state: 00 RUN, 01 LDSTALL, 10 MEMWAIT, 11 REDIR_PEND

Behaviour:
- Reset (iRst high at clock edge): state=RUN, pending-redirect flag=0.
- While reset is asserted, all stall/flush outputs are 0 and oFwdAE/oFwdBE=00. Outputs are combinational from state and inputs.
- Forwarding (combinational, every cycle), operand A:
  - 10 if iRegWriteM && iRdM!=0 && iRdM==iRs1E.
  - else 01 if iRegWriteW && iRdW!=0 && iRdW==iRs1E.
  - else 00.
  - M has priority over W. Operand B is identical using iRs2E. x0 is never forwarded.
- Load-use hit (loaduse) = iIsLoadE && iRdE!=0 && ((iUseRs1D && iRs1D==iRdE) || (iUseRs2D && iRs2D==iRdE)).
- Priority each cycle: iMemBusyM > iRedirectE > loaduse.
- MEMWAIT:
  - Entered/held whenever iMemBusyM=1: oStallF=oStallD=oStallE=oStallM=1, oFlushW=1, no D/E flush.
  - If iRedirectE=1 during MEMWAIT, set the pending flag; the redirect is not applied while busy.
  - When busy drops: go to REDIR_PEND if the flag is set, else RUN.
- Redirect in RUN (iRedirectE=1, not busy): oFlushD=oFlushE=1 in the same cycle, no stalls. Any simultaneous loaduse is ignored (the D instruction is squashed). Next state RUN.
- REDIR_PEND (one cycle): oFlushD=oFlushE=1, clear the flag, next state RUN. iMemBusyM=1 here overrides: go to MEMWAIT, flag stays set.
- Load-use in RUN: oStallF=oStallD=1, oFlushE=1, next state LDSTALL.
- LDSTALL (one cycle): no stall. The load is now in M and is forwarded. Next state RUN unless a new loaduse/busy/redirect applies by the priority rules.
  - Back-to-back load-use with a different load is legal and re-enters LDSTALL.
- Mid-operation reset in any state: return to RUN, flag cleared, on the same edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs oStallCnt and oFlushCnt (CNT_W each), reset to 0.
  - oStallCnt increments each cycle oStallF=1.
  - oFlushCnt increments each cycle oFlushE=1 due to redirect (not load-use bubbles).
  - Both wrap modulo 2^CNT_W.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles mid-LDSTALL -> oState=00, all stalls/flushes 0 the cycle after release.
- E: lw x5 (iIsLoadE=1, iRdE=5); D: add x6,x5,x7 (iUseRs1D=1, iRs1D=5) -> one cycle oStallF=oStallD=oFlushE=1, then oState=01. Next cycle with iRs1E=5, iRdM=5, iRegWriteM=1 -> oFwdAE=10, no stall.
- iRdE=0 load, iRs1D=0 -> no stall. iRdM=iRdW=3 both writing, iRs2E=3 -> oFwdBE=10 (M wins).
- iRedirectE=1 with loaduse true -> oFlushD=oFlushE=1, oStallF=0, state stays RUN.
- iMemBusyM=1 for 3 cycles with iRedirectE pulsed in cycle 2:
  - stalls F/D/E/M and oFlushW high for 3 cycles, oState=10;
  - then one cycle oState=11 with oFlushD=oFlushE=1;
  - then RUN.
- With HAZARD_PERF_CNT_EN: previous scenario -> oStallCnt=3, oFlushCnt=1. Preload counter to 2^CNT_W-1 via forced state -> wraps to 0.
